cmp_config_loader: RTL and testbench

CMP_CONFIG_LOADER -- requirements
Module: cmp_config_loader

---
 rtl/cmp_config_loader.sv | 160 ++++++++++++++++
 tb/tb_cmp_config_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_config_loader.sv
// Comparator configuration loader: parses a count/hash/terminator packet from a FWFT FIFO
// and writes the hash bytes into comparator memory, locking the comparator meanwhile.
module cmp_config_loader #(
  parameter int unsigned NUM_HASHES     = 512,
  parameter int unsigned HASH_NUM_MSB   = 8,
  parameter int unsigned HASH_COUNT_MSB = 9
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [7:0]                din,
  input  logic                      empty,
  output logic                      rd_en,
  input  logic                      cmp_idle,
  output logic                      cmp_lock,
  output logic [7:0]                dout,
  output logic                      wr_en,
  output logic [HASH_NUM_MSB+2:0]   wr_addr,
  output logic [HASH_COUNT_MSB:0]   hash_count,
  output logic                      cfg_valid,
  output logic                      error
);

  localparam int unsigned AddrW    = HASH_NUM_MSB + 3;
  localparam int unsigned TotW     = HASH_COUNT_MSB + 3;
  localparam logic [16:0] MaxCount = 17'(NUM_HASHES);

  typedef enum logic [2:0] {
    StIdle,
    StCntLo,
    StCntHi,
    StData,
    StTerm,
    StError
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              count_lo_q, count_lo_d;
  logic [AddrW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [AddrW-1:0]        wr_addr_q, wr_addr_d;
  logic [HASH_COUNT_MSB:0] hash_count_q, hash_count_d;
  logic [7:0]              dout_q, dout_d;
  logic                    wr_en_q, wr_en_d;
  logic                    cfg_valid_q, cfg_valid_d;

  logic [15:0]             count_in;
  logic                    count_bad;
  logic [TotW-1:0]         total_bytes;
  logic                    last_byte;

  assign count_in    = {din, count_lo_q};
  assign count_bad   = (count_in == 16'd0) || ({1'b0, count_in} > MaxCount);
  assign total_bytes = {hash_count_q, 2'b00};
  assign last_byte   = (TotW'(byte_cnt_q) == (total_bytes - TotW'(1)));

  always_comb begin
    state_d      = state_q;
    count_lo_d   = count_lo_q;
    byte_cnt_d   = byte_cnt_q;
    wr_addr_d    = wr_addr_q;
    hash_count_d = hash_count_q;
    dout_d       = dout_q;
    wr_en_d      = 1'b0;
    cfg_valid_d  = cfg_valid_q;
    rd_en        = 1'b0;
    cmp_lock     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // cmp_idle only matters here; once a packet starts it is ignored
        if (!empty && cmp_idle) begin
          state_d     = StCntLo;
          cfg_valid_d = 1'b0;
        end
      end
      StCntLo: begin
        cmp_lock = 1'b1;
        rd_en    = !empty;
        if (!empty) begin
          count_lo_d = din;
          state_d    = StCntHi;
        end
      end
      StCntHi: begin
        cmp_lock = 1'b1;
        rd_en    = !empty;
        if (!empty) begin
          if (count_bad) begin
            state_d = StError;
          end else begin
            hash_count_d = count_in[HASH_COUNT_MSB:0];
            byte_cnt_d   = '0;
            state_d      = StData;
          end
        end
      end
      StData: begin
        cmp_lock = 1'b1;
        rd_en    = !empty;
        if (!empty) begin
          dout_d    = din;
          wr_en_d   = 1'b1;
          wr_addr_d = byte_cnt_q;
          if (last_byte) begin
            state_d = StTerm;
          end else begin
            byte_cnt_d = byte_cnt_q + AddrW'(1);
          end
        end
      end
      StTerm: begin
        cmp_lock = 1'b1;
        rd_en    = !empty;
        if (!empty) begin
          if (din == 8'hCC) begin
            state_d     = StIdle;
            cfg_valid_d = 1'b1;
          end else begin
            state_d = StError;
          end
        end
      end
      StError: begin
        cfg_valid_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      count_lo_q   <= '0;
      byte_cnt_q   <= '0;
      wr_addr_q    <= '0;
      hash_count_q <= '0;
      dout_q       <= '0;
      wr_en_q      <= 1'b0;
      cfg_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_lo_q   <= count_lo_d;
      byte_cnt_q   <= byte_cnt_d;
      wr_addr_q    <= wr_addr_d;
      hash_count_q <= hash_count_d;
      dout_q       <= dout_d;
      wr_en_q      <= wr_en_d;
      cfg_valid_q  <= cfg_valid_d;
    end
  end

  assign dout       = dout_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign hash_count = hash_count_q;
  assign cfg_valid  = cfg_valid_q;
  assign error      = (state_q == StError);

endmodule

// File: tb/tb_cmp_config_loader.sv
// Directed bench for cmp_config_loader: a per-cycle vector table for two packets, then
// FIFO-driven sequences for stalls, lock-out, reset abort and count boundaries.
module tb_cmp_config_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        empty;
  logic        rd_en;
  logic        cmp_idle;
  logic        cmp_lock;
  logic [7:0]  dout;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [9:0]  hash_count;
  logic        cfg_valid;
  logic        error;

  cmp_config_loader #(
    .NUM_HASHES    (512),
    .HASH_NUM_MSB  (8),
    .HASH_COUNT_MSB(9)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .din       (din),
    .empty     (empty),
    .rd_en     (rd_en),
    .cmp_idle  (cmp_idle),
    .cmp_lock  (cmp_lock),
    .dout      (dout),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .hash_count(hash_count),
    .cfg_valid (cfg_valid),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  din;
    logic        empty;
    logic        idle;
    logic        rd;
    logic        wr;
    logic [7:0]  dout;
    logic [10:0] addr;
    logic        lock;
    logic        valid;
    logic        err;
    logic [9:0]  hc;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] fifo[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         pidx;
  int         nwr;
  logic       gate;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] d, input logic e, input logic i, input logic r,
                     input logic w, input logic [7:0] o, input logic [10:0] a, input logic l,
                     input logic v, input logic er, input logic [9:0] h);
    vec_t t;
    t.din = d; t.empty = e; t.idle = i; t.rd = r; t.wr = w; t.dout = o; t.addr = a;
    t.lock = l; t.valid = v; t.err = er; t.hc = h;
    tbl.push_back(t);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din = 8'h00;
    empty = 1'b1;
    gate = 1'b0;
    fifo.delete();
    pidx = 0;
    nwr = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // FIFO-driven run; writes are expected one cycle after each data byte is consumed
  task automatic run(input int ncyc, input bit toggle, input int dfirst, input int dn);
    int         last_pop;
    logic [7:0] last_byte;
    logic       exp_wr;
    last_pop = -1;
    last_byte = 8'h00;
    nwr = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      gate = toggle ? ~gate : 1'b0;
      empty = gate || (fifo.size() == 0);
      din = (fifo.size() != 0) ? fifo[0] : 8'h00;
      #1;
      exp_wr = (last_pop >= dfirst) && (last_pop < dfirst + dn);
      chk("run_wr_en", {31'd0, wr_en}, {31'd0, exp_wr});
      if (exp_wr) begin
        chk("run_dout", {24'd0, dout}, {24'd0, last_byte});
        chk("run_wr_addr", {21'd0, wr_addr}, last_pop - dfirst);
      end
      if (wr_en) nwr++;
      last_pop = -1;
      if (rd_en && !empty) begin
        last_byte = fifo.pop_front();
        last_pop = pidx;
        pidx++;
      end
    end
  endtask

  task automatic push_std();
    logic [7:0] b[7];
    b = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hCC};
    foreach (b[i]) fifo.push_back(b[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    cmp_idle = 1'b1;
    do_reset();

    // din empty idle rd wr dout addr lock valid err hc
    add(8'h01, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    add(8'h01, 0, 1, 1, 0, 8'h00, 0, 1, 0, 0, 0);
    add(8'h00, 0, 1, 1, 0, 8'h00, 0, 1, 0, 0, 0);
    add(8'h11, 0, 1, 1, 0, 8'h00, 0, 1, 0, 0, 1);
    add(8'h22, 0, 1, 1, 1, 8'h11, 0, 1, 0, 0, 1);
    add(8'h33, 0, 1, 1, 1, 8'h22, 1, 1, 0, 0, 1);
    add(8'h44, 0, 1, 1, 1, 8'h33, 2, 1, 0, 0, 1);
    add(8'hCC, 0, 1, 1, 1, 8'h44, 3, 1, 0, 0, 1);
    add(8'h00, 1, 1, 0, 0, 8'h00, 0, 0, 1, 0, 1);
    add(8'h02, 0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 1);
    add(8'h02, 0, 1, 1, 0, 8'h00, 0, 1, 0, 0, 1);
    add(8'h00, 0, 1, 1, 0, 8'h00, 0, 1, 0, 0, 1);
    add(8'hA0, 0, 1, 1, 0, 8'h00, 0, 1, 0, 0, 2);
    for (int i = 1; i < 8; i++)
      add(8'hA0 + 8'(i), 0, 1, 1, 1, 8'hA0 + 8'(i - 1), 11'(i - 1), 1, 0, 0, 2);
    add(8'hAB, 0, 1, 1, 1, 8'hA7, 7, 1, 0, 0, 2);
    add(8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0, 1, 2);
    add(8'hCC, 0, 1, 0, 0, 8'h00, 0, 0, 0, 1, 2);

    for (int v = 0; v < tbl.size(); v++) begin
      @(negedge clk);
      din = tbl[v].din;
      empty = tbl[v].empty;
      cmp_idle = tbl[v].idle;
      #1;
      chk($sformatf("tbl%0d_rd_en", v), {31'd0, rd_en}, {31'd0, tbl[v].rd});
      chk($sformatf("tbl%0d_wr_en", v), {31'd0, wr_en}, {31'd0, tbl[v].wr});
      if (tbl[v].wr) begin
        chk($sformatf("tbl%0d_dout", v), {24'd0, dout}, {24'd0, tbl[v].dout});
        chk($sformatf("tbl%0d_wr_addr", v), {21'd0, wr_addr}, {21'd0, tbl[v].addr});
      end
      chk($sformatf("tbl%0d_lock", v), {31'd0, cmp_lock}, {31'd0, tbl[v].lock});
      chk($sformatf("tbl%0d_valid", v), {31'd0, cfg_valid}, {31'd0, tbl[v].valid});
      chk($sformatf("tbl%0d_error", v), {31'd0, error}, {31'd0, tbl[v].err});
      chk($sformatf("tbl%0d_hc", v), {22'd0, hash_count}, {22'd0, tbl[v].hc});
    end

    // Stalls every other cycle: same write stream, no duplicates
    do_reset();
    push_std();
    run(24, 1'b1, 2, 4);
    chk("toggle_nwr", nwr, 4);
    chk("toggle_hc", {22'd0, hash_count}, 1);
    chk("toggle_valid", {31'd0, cfg_valid}, 1);

    // Comparator busy: packet held off until cmp_idle rises
    do_reset();
    cmp_idle = 1'b0;
    push_std();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      empty = 1'b0;
      din = fifo[0];
      #1;
      chk("busy_rd_en", {31'd0, rd_en}, 0);
      chk("busy_lock", {31'd0, cmp_lock}, 0);
    end
    cmp_idle = 1'b1;
    run(10, 1'b0, 2, 4);
    chk("busy_nwr", nwr, 4);
    chk("busy_valid", {31'd0, cfg_valid}, 1);
    chk("busy_hc", {22'd0, hash_count}, 1);

    // Count 513 is out of range; hash_count keeps the previous value
    fifo.push_back(8'h01); fifo.push_back(8'h02);
    fifo.push_back(8'hAA); fifo.push_back(8'hBB);
    run(5, 1'b0, 0, 0);
    chk("big_error", {31'd0, error}, 1);
    chk("big_hc", {22'd0, hash_count}, 1);
    chk("big_valid", {31'd0, cfg_valid}, 0);
    chk("big_lock", {31'd0, cmp_lock}, 0);
    chk("big_rd_en", {31'd0, rd_en}, 0);

    // Count 0 is rejected
    do_reset();
    fifo.push_back(8'h00); fifo.push_back(8'h00); fifo.push_back(8'hCC);
    run(4, 1'b0, 0, 0);
    chk("zero_error", {31'd0, error}, 1);
    chk("zero_hc", {22'd0, hash_count}, 0);

    // Reset mid-DATA aborts; leftover bytes form a new packet
    do_reset();
    fifo.push_back(8'h02); fifo.push_back(8'h00);
    fifo.push_back(8'hAA); fifo.push_back(8'hBB);
    push_std();
    run(5, 1'b0, 2, 8);
    @(posedge clk);
    #2;
    chk("pre_rst_wr_en", {31'd0, wr_en}, 1);
    rst = 1'b1;
    #1;
    chk("rst_wr_en", {31'd0, wr_en}, 0);
    chk("rst_rd_en", {31'd0, rd_en}, 0);
    chk("rst_dout", {24'd0, dout}, 0);
    chk("rst_wr_addr", {21'd0, wr_addr}, 0);
    chk("rst_hc", {22'd0, hash_count}, 0);
    chk("rst_lock", {31'd0, cmp_lock}, 0);
    chk("rst_valid", {31'd0, cfg_valid}, 0);
    chk("rst_error", {31'd0, error}, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pidx = 0;
    gate = 1'b0;
    run(10, 1'b0, 2, 4);
    chk("abort_nwr", nwr, 4);
    chk("abort_hc", {22'd0, hash_count}, 1);
    chk("abort_valid", {31'd0, cfg_valid}, 1);

    // Maximum count 512 fills addresses 0..2047
    do_reset();
    fifo.push_back(8'h00); fifo.push_back(8'h02);
    for (int i = 0; i < 2048; i++) fifo.push_back(8'((i * 7) ^ (i >> 8)));
    fifo.push_back(8'hCC);
    run(2056, 1'b0, 2, 2048);
    chk("max_nwr", nwr, 2048);
    chk("max_hc", {22'd0, hash_count}, 512);
    chk("max_valid", {31'd0, cfg_valid}, 1);
    chk("max_error", {31'd0, error}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
